// File: rtl/wb_synth_pkg.sv
// Shared types for the writeback-to-synthesizer command scheduler: opcodes,
// FSM states, the queued command entry and the opcode priority decode.
package wb_synth_pkg;

  localparam int DEF_IMMW  = 11;
  localparam int DEF_DATAW = 32;

  typedef enum logic [1:0] {
    OP_SET_FREQ = 2'd0,
    OP_SET_EN   = 2'd1,
    OP_SYN      = 2'd2
  } synth_op_t;

  typedef enum logic {
    S_IDLE,
    S_WAIT_DONE
  } sched_state_t;

  typedef struct packed {
    synth_op_t             op;
    logic [DEF_IMMW-1:0]   imm;
    logic [DEF_DATAW-1:0]  data;
  } synth_entry_t;

  // SYN outranks SET_FREQ, which outranks SET_EN.
  function automatic synth_op_t select_op(input logic syn, input logic set_freq);
    if (syn)           return OP_SYN;
    else if (set_freq) return OP_SET_FREQ;
    else               return OP_SET_EN;
  endfunction

endpackage

// File: rtl/synth_cmd_fifo.sv
// Parameterized synchronous FIFO with a separate occupancy counter; the
// caller guarantees no push when full and no pop when empty.
module synth_cmd_fifo #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push_i) wrPtr_d = wrPtr_q + AW'(1);
    if (pop_i)  rdPtr_d = rdPtr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed when count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wrPtr_q] <= data_i;
  end

  assign data_o  = mem_q[rdPtr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/wb_synth_scheduler.sv
// Captures synthesizer-control instructions leaving writeback, queues them and
// issues them over valid/ready, holding further commands while a SYN runs.
module wb_synth_scheduler
  import wb_synth_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IMMW  = 11,
  parameter int DATAW = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_valid,
  input  logic                    wb_syn,
  input  logic                    wb_set_en,
  input  logic                    wb_set_freq,
  input  logic [IMMW-1:0]         wb_imm,
  input  logic [DATAW-1:0]        wb_data,
  output logic                    stall_out,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [1:0]              cmd_op,
  output logic [IMMW-1:0]         cmd_imm,
  output logic [DATAW-1:0]        cmd_data,
  input  logic                    synth_done,
  output logic [$clog2(DEPTH):0]  pending,
  output logic                    idle,
  output logic                    multi_err
);

  localparam int EW = 2 + IMMW + DATAW;
  localparam int CW = $clog2(DEPTH) + 1;

  logic           cmdPresent;
  logic           multiFlag;
  logic           push;
  logic           pop;
  logic           fifoFull;
  logic           fifoEmpty;
  logic [EW-1:0]  pushEntry;
  logic [EW-1:0]  headEntry;
  logic [CW-1:0]  count;
  synth_op_t      pushOp;
  synth_op_t      headOp;
  sched_state_t   state_q, state_d;
  logic           multiErr_q, multiErr_d;

  assign cmdPresent = wb_valid & (wb_syn | wb_set_en | wb_set_freq);
  assign multiFlag  = (wb_syn & wb_set_en) | (wb_syn & wb_set_freq) | (wb_set_en & wb_set_freq);
  assign pushOp     = select_op(wb_syn, wb_set_freq);
  assign pushEntry  = {pushOp, wb_imm, wb_data};

  // Stall looks only at occupancy, so a same-cycle pop never lets a push in.
  assign stall_out = cmdPresent & fifoFull;
  assign push      = cmdPresent & ~fifoFull;
  assign pop       = cmd_valid & cmd_ready;

  synth_cmd_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (pushEntry),
    .pop_i   (pop),
    .data_o  (headEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (count)
  );

  assign headOp = synth_op_t'(headEntry[EW-1 -: 2]);

  always_comb begin
    state_d    = state_q;
    cmd_valid  = 1'b0;
    multiErr_d = multiErr_q | (cmdPresent & multiFlag);
    case (state_q)
      S_IDLE: begin
        cmd_valid = ~fifoEmpty;
        if (cmd_valid && cmd_ready && (headOp == OP_SYN)) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (synth_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      multiErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      multiErr_q <= multiErr_d;
    end
  end

  // Payload is forced to zero whenever nothing is offered.
  assign cmd_op    = cmd_valid ? headEntry[EW-1 -: 2]       : 2'b00;
  assign cmd_imm   = cmd_valid ? headEntry[DATAW +: IMMW]   : '0;
  assign cmd_data  = cmd_valid ? headEntry[DATAW-1:0]       : '0;
  assign pending   = count;
  assign idle      = fifoEmpty & (state_q == S_IDLE);
  assign multi_err = multiErr_q;

endmodule

// File: tb/tb_wb_synth_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a queue-based reference model of the scheduler.
module tb_wb_synth_scheduler;
  import wb_synth_pkg::*;

  localparam int DEPTH = 4;
  localparam int IMMW  = 11;
  localparam int DATAW = 32;

  logic             clk;
  logic             rst_n;
  logic             wb_valid, wb_syn, wb_set_en, wb_set_freq;
  logic [IMMW-1:0]  wb_imm;
  logic [DATAW-1:0] wb_data;
  logic             stall_out, cmd_valid, cmd_ready;
  logic [1:0]       cmd_op;
  logic [IMMW-1:0]  cmd_imm;
  logic [DATAW-1:0] cmd_data;
  logic             synth_done;
  logic [$clog2(DEPTH):0] pending;
  logic             idle, multi_err;

  int checks = 0;
  int fails  = 0;
  bit running = 0;

  // Reference model: queued commands, busy-with-SYN flag, sticky error.
  synth_entry_t modelQ[$];
  bit modelWait  = 0;
  bit modelMulti = 0;

  wb_synth_scheduler #(.DEPTH(DEPTH), .IMMW(IMMW), .DATAW(DATAW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_syn(wb_syn), .wb_set_en(wb_set_en), .wb_set_freq(wb_set_freq),
    .wb_imm(wb_imm), .wb_data(wb_data),
    .stall_out(stall_out),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm), .cmd_data(cmd_data),
    .synth_done(synth_done),
    .pending(pending), .idle(idle), .multi_err(multi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic synth_op_t refOp(input logic syn, input logic freq);
    if (syn)  return OP_SYN;
    if (freq) return OP_SET_FREQ;
    return OP_SET_EN;
  endfunction

  // Runs mid-cycle: compare this cycle's outputs, then advance the model
  // across the coming rising edge using the (stable) inputs.
  always @(negedge clk) begin
    if (running) begin
      if (!rst_n) begin
        modelQ.delete();
        modelWait  = 0;
        modelMulti = 0;
        checkOutput("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        checkOutput("rst_pending",   64'(pending),   64'd0);
        checkOutput("rst_idle",      64'(idle),      64'd1);
        checkOutput("rst_multi_err", 64'(multi_err), 64'd0);
        checkOutput("rst_cmd_data",  64'(cmd_data),  64'd0);
      end else begin
        automatic bit present  = wb_valid && (wb_syn || wb_set_en || wb_set_freq);
        automatic int nFlags   = int'(wb_syn) + int'(wb_set_en) + int'(wb_set_freq);
        automatic int sizeNow  = modelQ.size();
        automatic bit expValid = !modelWait && (sizeNow > 0);
        automatic synth_entry_t head;
        automatic synth_entry_t newEntry;

        checkOutput("cmd_valid", 64'(cmd_valid), 64'(expValid));
        checkOutput("pending",   64'(pending),   64'(sizeNow));
        checkOutput("idle",      64'(idle),      64'(sizeNow == 0 && !modelWait));
        checkOutput("multi_err", 64'(multi_err), 64'(modelMulti));
        checkOutput("stall_out", 64'(stall_out), 64'(present && sizeNow == DEPTH));

        if (expValid) begin
          head = modelQ[0];
          checkOutput("cmd_op",   64'(cmd_op),   64'(head.op));
          checkOutput("cmd_imm",  64'(cmd_imm),  64'(head.imm));
          checkOutput("cmd_data", 64'(cmd_data), 64'(head.data));
        end else begin
          checkOutput("cmd_zero", 64'({cmd_op, cmd_imm, cmd_data}), 64'd0);
        end

        if (modelWait && synth_done) modelWait = 0;
        if (expValid && cmd_ready) begin
          head = modelQ.pop_front();
          if (head.op == OP_SYN) modelWait = 1;
        end
        if (present && sizeNow < DEPTH) begin
          newEntry.op   = refOp(wb_syn, wb_set_freq);
          newEntry.imm  = wb_imm;
          newEntry.data = wb_data;
          modelQ.push_back(newEntry);
        end
        if (present && nFlags > 1) modelMulti = 1;
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic syn, input logic en, input logic freq,
                               input logic [IMMW-1:0] imm, input logic [DATAW-1:0] data,
                               input logic ready, input logic done);
    @(posedge clk);
    #1;
    wb_valid    = v;
    wb_syn      = syn;
    wb_set_en   = en;
    wb_set_freq = freq;
    wb_imm      = imm;
    wb_data     = data;
    cmd_ready   = ready;
    synth_done  = done;
  endtask

  task automatic idleCycles(input int n, input logic ready);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, '0, '0, ready, 0);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    wb_valid = 0; wb_syn = 0; wb_set_en = 0; wb_set_freq = 0;
    wb_imm = '0; wb_data = '0; cmd_ready = 0; synth_done = 0;
    #2;
    rst_n   = 1'b0;
    running = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] single SET_FREQ");
    applyStimulus(1, 0, 0, 1, 11'd5, 32'h1234, 1, 0);
    idleCycles(3, 1);

    $display("[TB] fill with ready low");
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 0, (i % 2 == 0), (i % 2 == 1), IMMW'(i + 1), 32'hA000 + DATAW'(i), 0, 0);
    idleCycles(2, 0);
    idleCycles(6, 1);

    $display("[TB] SYN then SET_EN");
    applyStimulus(1, 1, 0, 0, 11'd7, 32'hBEEF, 1, 0);
    applyStimulus(1, 0, 1, 0, 11'd8, 32'hCAFE, 1, 0);
    idleCycles(9, 1);
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 1);
    idleCycles(4, 1);

    $display("[TB] multiple flags");
    applyStimulus(1, 1, 0, 1, 11'h3FF, 32'hDEAD0001, 1, 0);
    idleCycles(3, 1);
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 1);
    idleCycles(2, 1);

    $display("[TB] push and pop together");
    applyStimulus(1, 0, 1, 0, 11'd1, 32'h11, 0, 0);
    applyStimulus(1, 0, 0, 1, 11'd2, 32'h22, 0, 0);
    applyStimulus(1, 0, 1, 0, 11'd3, 32'h33, 1, 0);
    applyStimulus(1, 0, 0, 1, 11'd4, 32'h44, 0, 0);
    applyStimulus(1, 0, 1, 0, 11'd5, 32'h55, 0, 0);
    applyStimulus(1, 0, 0, 1, 11'd6, 32'h66, 1, 0);
    idleCycles(6, 1);

    $display("[TB] reset during WAIT_DONE");
    applyStimulus(1, 1, 0, 0, 11'd9, 32'h99, 1, 0);
    applyStimulus(1, 0, 1, 0, 11'd10, 32'hA1, 1, 0);
    applyStimulus(1, 0, 0, 1, 11'd11, 32'hA2, 1, 0);
    applyStimulus(1, 0, 1, 0, 11'd12, 32'hA3, 1, 0);
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 0);
    pulseReset();
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 1);
    idleCycles(3, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      automatic logic [2:0] fl = 3'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 3) != 0), fl[2], fl[1], fl[0],
                    IMMW'($urandom_range(0, 2047)), DATAW'($urandom),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0));
    end
    idleCycles(2, 1);
    @(posedge clk);
    #1;
    running = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/wb_synth_scheduler.md
# wb_synth_scheduler

Command scheduler between the MEM/WB pipeline register and the synthesizer core. It captures synthesizer-control instructions (SET_FREQ, SET_EN, SYN) as they leave writeback and buffers them in a small FIFO. It issues them to the synthesizer over a valid/ready handshake and serializes around SYN by holding further commands until the synthesizer reports completion. It back-pressures the pipeline with a stall when the buffer cannot accept.

## Interface
Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- IMMW, 11, immediate width
- DATAW, 32, command data width (low DATAW bits of writeback data)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wb_valid  in  1  writeback instruction valid
- wb_syn, wb_set_en, wb_set_freq  in  1 each  writeback command flags
- wb_imm  in  IMMW  writeback immediate
- wb_data  in  DATAW  writeback data (low word)
- stall_out  out  1  stall request to pipeline (combinational)
- cmd_valid  out  1  command offered to synthesizer
- cmd_ready  in  1  synthesizer accepts command
- cmd_op  out  2  opcode: 0 SET_FREQ, 1 SET_EN, 2 SYN
- cmd_imm  out  IMMW  command immediate
- cmd_data  out  DATAW  command data
- synth_done  in  1  one-cycle pulse, SYN finished
- pending  out  $clog2(DEPTH)+1  FIFO occupancy
- idle  out  1  FIFO empty and state IDLE
- multi_err  out  1  sticky: instruction carried more than one flag

## Operation
- Command present = wb_valid & (wb_syn | wb_set_en | wb_set_freq).
- Opcode select priority: SYN > SET_FREQ > SET_EN. If more than one flag is set, push one entry with the winning opcode and set multi_err. multi_err clears only on reset.
- stall_out = command present & (pending == DEPTH). A pop in the same cycle does not release the stall.
- Push when command present & !stall_out: {op, imm, data} is written at the tail.
- FSM:
  - IDLE: cmd_valid = 1 when FIFO non-empty, head shown on cmd_*.
  - Handshake (cmd_valid & cmd_ready) pops the head.
  - Popped op SYN → WAIT_DONE. Any other op stays in IDLE.
  - WAIT_DONE: cmd_valid = 0. synth_done → IDLE.
  - synth_done outside WAIT_DONE is ignored.
- Payload is stable while cmd_valid & !cmd_ready. cmd_* outputs are 0 when cmd_valid = 0.
- Simultaneous push and pop when non-full: both happen, pending unchanged.
- Pointers wrap modulo DEPTH. Occupancy is tracked with a separate counter.
- Reset (any time, including mid-handshake or in WAIT_DONE): FIFO emptied, state IDLE, all outputs 0, multi_err 0. idle = 1 after reset.

## Timing
- Push-to-issue latency: an entry pushed at edge N is on cmd_valid during cycle N+1 (FIFO empty, IDLE).
- Back-to-back non-SYN commands with cmd_ready held high: one issue per cycle.
- After a SYN handshake at edge N: cmd_valid is low from cycle N+1 until synth_done. With synth_done sampled at edge M, the next command is offered in cycle M+1.
- stall_out is the only combinational output; all others are registered or decoded from state/FIFO registers.

## Structure
- Shared package wb_synth_pkg holds the typedef enum logic [1:0] synth_op_t {OP_SET_FREQ, OP_SET_EN, OP_SYN}, the FSM state enum {S_IDLE, S_WAIT_DONE}, and the packed entry struct {op, imm, data}.
- One sub-module: synth_cmd_fifo, a parameterized synchronous FIFO with push/pop/full/empty/count and async active-low reset. The scheduler top holds the flag decode, stall logic and FSM.

## Test plan
- Reset then single SET_FREQ: imm=5, data=0x1234 → cmd_valid in next cycle with op 0, imm 5, data 0x1234; pop on ready; idle = 1 afterwards.
- Fill with cmd_ready=0: push 5 commands at DEPTH=4 → stall_out high on the 5th; pending = 4; no entry lost once ready rises; issue order preserved.
- SYN then SET_EN with ready=1 → SYN issued; cmd_valid low until synth_done pulse 10 cycles later; SET_EN offered the cycle after the pulse.
- Flags syn=1 and set_freq=1 together → one SYN entry, multi_err = 1 and stays set.
- Push and pop in the same cycle at pending=2 → pending stays 2; the full case with a pop still asserts stall_out.
- rst_n low while in WAIT_DONE with 3 entries queued → pending = 0, cmd_valid = 0, idle = 1; a later synth_done has no effect.
